// File: rtl/load_store_unit_pkg.sv
// Shared encodings and request helpers for the load/store unit: RV32I func3
// widths, FSM states, byte-enable patterns and the legality/lane functions.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // A request that can never reach memory: conflicting, unknown width or misaligned.
    function automatic logic req_illegal(input logic       rd,
                                         input logic       wr,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
        logic ill;
        ill = 1'b0;
        if (rd && wr) begin
            ill = 1'b1;
        end else if (rd) begin
            case (f3)
                3'b011, 3'b110, 3'b111: ill = 1'b1;
                default:                ill = 1'b0;
            endcase
        end else if (wr) begin
            case (f3)
                F3_SB, F3_SH, F3_SW: ill = 1'b0;
                default:             ill = 1'b1;
            endcase
        end else begin
            ill = 1'b0;
        end
        if ((f3[1:0] == SZ_HALF) && off[0]) begin
            ill = 1'b1;
        end else if ((f3[1:0] == SZ_WORD) && (off != 2'b00)) begin
            ill = 1'b1;
        end else begin
            ill = ill;
        end
        return ill;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] f3,
                                               input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            SZ_BYTE: be = BE_BYTE << off;
            SZ_HALF: be = BE_HALF << off;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    // Stores replicate the datum into every lane so the enables alone pick the target.
    function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                                input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3[1:0])
            SZ_BYTE: lanes = {4{wd[7:0]}};
            SZ_HALF: lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide data-memory bus with a req/ack handshake; the LSU is the master.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Lane-selects a memory word by byte offset and sign/zero-extends it to 32 bits
// according to the RV32I load func3.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  func3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and halfword lanes.
    always_comb begin
        byte_s = 8'd0;
        case (offset_i)
            2'b00:   byte_s = mem_rdata_i[7:0];
            2'b01:   byte_s = mem_rdata_i[15:8];
            2'b10:   byte_s = mem_rdata_i[23:16];
            2'b11:   byte_s = mem_rdata_i[31:24];
            default: byte_s = 8'd0;
        endcase
        if (offset_i[1]) begin
            half_s = mem_rdata_i[31:16];
        end else begin
            half_s = mem_rdata_i[15:0];
        end
    end

    // Extend the selected lane; unknown widths yield zero.
    always_comb begin
        data_o = 32'd0;
        case (func3_i)
            F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
            F3_LH:   data_o = {{16{half_s[15]}}, half_s};
            F3_LW:   data_o = mem_rdata_i;
            F3_LBU:  data_o = {24'd0, byte_s};
            F3_LHU:  data_o = {16'd0, half_s};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core load/store requests into byte-enabled word accesses,
// stalls the core until memory acks, and flags illegal and timed-out accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [2:0]                func3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    output logic                      stall,
    output logic                      done,
    output logic                      err,
    load_store_unit_if.master         mem
);

    lsu_state_e        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              we_q,     we_d;
    logic [2:0]        func3_q,  func3_d;
    logic [1:0]        off_q,    off_d;
    logic [31:0]       maddr_q,  maddr_d;
    logic [3:0]        be_q,     be_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [31:0]       rdata_q,  rdata_d;
    logic              err_q,    err_d;

    logic              start_s;
    logic              illegal_s;
    logic              stall_s;
    logic [31:0]       ext_s;

    assign start_s   = MemRead | MemWrite;
    assign illegal_s = req_illegal(MemRead, MemWrite, func3, addr[1:0]);

    load_extend u_load_extend (
        .mem_rdata_i (mem.mem_rdata),
        .offset_i    (off_q),
        .func3_i     (func3_q),
        .data_o      (ext_s)
    );

    // Next-state, request capture and response formation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        func3_d  = func3_q;
        off_d    = off_q;
        maddr_d  = maddr_q;
        be_d     = be_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        stall_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_s = start_s;
                cnt_d   = {CNT_W{1'b0}};
                if (start_s && illegal_s) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end else if (start_s) begin
                    we_d     = MemWrite;
                    func3_d  = func3;
                    off_d    = addr[1:0];
                    maddr_d  = {addr[31:2], 2'b00};
                    be_d     = byte_enable(func3, addr[1:0]);
                    mwdata_d = store_lanes(func3, wdata);
                    rdata_d  = 32'd0;
                    state_d  = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_s = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                // An ack on the last allowed cycle still completes normally.
                if (mem.mem_ack) begin
                    if (we_q) begin
                        rdata_d = 32'd0;
                    end else begin
                        rdata_d = ext_s;
                    end
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RESP: begin
                cnt_d   = {CNT_W{1'b0}};
                err_d   = 1'b0;
                rdata_d = 32'd0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = {CNT_W{1'b0}};
                err_d   = 1'b0;
                rdata_d = 32'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            we_q     <= 1'b0;
            func3_q  <= 3'd0;
            off_q    <= 2'd0;
            maddr_q  <= 32'd0;
            be_q     <= 4'd0;
            mwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            func3_q  <= func3_d;
            off_q    <= off_d;
            maddr_q  <= maddr_d;
            be_q     <= be_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign stall         = stall_s;
    assign done          = (state_q == ST_RESP);
    assign err           = err_q;
    assign rdata         = rdata_q;
    assign mem.mem_req   = (state_q == ST_BUSY);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = mwdata_q;

endmodule
